mvu_pe_simd_acc: RTL
====================

MVU_PE_SIMD_ACC -- requirements
Module: mvu_pe_simd_acc

Interface
REQ-001 SHALL have parameter SIMD, default 4: number of parallel multiply lanes (power of two, 1..64).
REQ-002 SHALL have parameter TSRCI, default 4: activation word length per lane, signed two's complement.
REQ-003 SHALL have parameter TW, default 4: weight word length per lane, signed two's complement.
REQ-004 SHALL have parameter TDSTI, default 16: accumulator and output word length (>= TSRCI+TW+log2(SIMD)).
REQ-005 SHALL have parameter SF, default 8: number of folds (input beats) accumulated per output.
REQ-006 SHALL have ports:
- clk  in  1  main clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- in_v  in  1  input beat valid.
- in_rdy  out  1  input beat accepted when in_v && in_rdy.
- in_act  in  SIMD*TSRCI  packed activations, lane i at [i*TSRCI +: TSRCI].
- in_wgt  in  SIMD*TW  packed weights, same lane packing.
- out_v  out  1  result valid.
- out_rdy  in  1  downstream ready.
- out  out  TDSTI  dot-product result over SF folds.

Function
REQ-007 SHALL compute, per accepted beat, p = sum over lanes of signed(in_act[i]) * signed(in_wgt[i]), sign-extended to TDSTI.
REQ-008 SHALL use a 3-stage pipeline: S1 registers the lane products; S2 registers the adder-tree sum; S3 updates the accumulator.
REQ-009 SHALL use one global pipeline enable: en = !(out_v && !out_rdy). When en=0, all stage registers, valid bits and the fold counter hold their values.
REQ-010 SHALL drive in_rdy = en, combinationally.
REQ-011 SHALL keep a fold counter (0..SF-1) that advances on each beat reaching S3 and wraps from SF-1 to 0.
REQ-012 SHALL, at S3 with fold 0, load acc = p; with fold k>0, set acc = acc + p, modulo 2^TDSTI by default.
REQ-013 SHALL, at S3 with fold SF-1, write the final sum to out and set out_v=1 in that same edge. The latency from the first beat's acceptance to out_v is therefore SF+2 cycles with no bubbles.
REQ-014 SHALL clear out_v on an edge where out_v && out_rdy && no new final fold completes. If a new final fold completes on the same edge as a handshake, out and out_v=1 SHALL be reloaded (back-to-back).
REQ-015 SHALL treat input bubbles (in_v=0) as pipeline holes. Holes do not advance the fold counter and do not alter acc.
REQ-016 SHALL, with SF=1, produce out equal to p of every beat, with a throughput of 1 per cycle.
REQ-017 SHALL keep out stable while out_v && !out_rdy.

Reset
REQ-018 SHALL, on rst_n=0 at any time (including mid-vector), asynchronously clear: all stage valid bits, fold counter, acc, out (0) and out_v (0).
REQ-019 SHALL drive in_rdy=1 while in reset-released idle. Partial accumulations lost to reset are not recovered.

Configuration
REQ-020 SHALL support macro MVU_PE_SAT_EN. When it is defined, REQ-012 additions saturate to the range [-2^(TDSTI-1), 2^(TDSTI-1)-1] and the saturated value persists through the remaining folds. When it is undefined, additions wrap modulo 2^TDSTI.

Structure
REQ-021 SHALL take the lane-count log2, the product-width constant and a signed accumulator typedef from the shared mvau_defn.sv definitions.
REQ-022 SHALL instantiate one sub-module, mvu_pe_adder_tree, parametrised by SIMD and input width. It is combinational between the S1 and S2 registers.

Verification
REQ-023 Check SIMD=4, SF=2: beats act={1,2,3,4} wgt={1,1,1,1}, then act={-1,-1,-1,-1} wgt={2,2,2,2}, with out_rdy=1 -> out=2, out_v=1 for one cycle, 4 cycles after the first beat.
REQ-024 Check back-pressure: hold out_rdy=0 with a result pending -> in_rdy=0, out stable, no fold counter change; release -> the next vector's result is correct.
REQ-025 Check wrap vs saturation: TDSTI=8, SF=4, each beat p=100 -> out=-112 (wrap) without the macro, and out=127 with MVU_PE_SAT_EN.
REQ-026 Check reset: assert rst_n=0 after fold 1 of SF=4, then send a full vector -> the result excludes the pre-reset beats, and out_v=0 during reset.
REQ-027 Check bubbles and throughput: random in_v gaps over 100 vectors against a reference model -> all results match, and back-to-back vectors with out_rdy=1 show no lost cycle.
REQ-028 Check signed extremes: TSRCI=TW=4, all lanes -8 * -8, SIMD=4, SF=1 -> out=256.

Source files
------------

// File: rtl/mvu_pe_simd_acc_pkg.sv
// Shared MVAU definitions: width helpers and the wide signed accumulator type
// used by the SIMD processing element and its adder tree.
package mvu_pe_simd_acc_pkg;

    // Widest signed accumulator the PE ever needs for an intermediate sum.
    localparam int ACC_MAX_W = 64;
    typedef logic signed [ACC_MAX_W-1:0] acc_wide_t;

    // log2 of the lane count; a single lane adds no tree levels.
    function automatic int lane_log2(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Full-precision width of one signed activation x weight product.
    function automatic int prod_width(input int tsrci, input int tw);
        return tsrci + tw;
    endfunction

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int count_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mvu_pe_simd_acc_adder_tree.sv
// Combinational signed sum of SIMD lane products, sitting between the
// product register and the sum register of the PE pipeline.
module mvu_pe_adder_tree
    import mvu_pe_simd_acc_pkg::*;
#(
    parameter int SIMD = 4,
    parameter int IW   = 8,
    parameter int OW   = IW + lane_log2(SIMD)
) (
    input  logic [SIMD*IW-1:0] terms,
    output logic signed [OW-1:0] sum
);

    // Sign-extend every lane to the output width and add; synthesis balances the chain.
    always_comb begin
        sum = '0;
        for (int i = 0; i < SIMD; i++) begin
            sum = sum + OW'($signed(terms[i*IW +: IW]));
        end
    end

endmodule

// File: rtl/mvu_pe_simd_acc.sv
// SIMD multiply-accumulate processing element: SIMD signed lane products per
// beat, reduced by an adder tree and accumulated over SF folds.
// Pipeline: S1 products -> S2 tree sum -> S3 accumulator/output register.
// Handshake: a beat moves when in_v && in_rdy; a result leaves when
// out_v && out_rdy. One global enable stalls the whole pipeline while a
// result is waiting on a busy consumer, so in_rdy simply equals that enable.
// Build option: define MVU_PE_SAT_EN to saturate accumulation instead of
// wrapping modulo 2^TDSTI.
module mvu_pe_simd_acc
    import mvu_pe_simd_acc_pkg::*;
#(
    parameter int SIMD  = 4,
    parameter int TSRCI = 4,
    parameter int TW    = 4,
    parameter int TDSTI = 16,
    parameter int SF    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_v,
    output logic                  in_rdy,
    input  logic [SIMD*TSRCI-1:0] in_act,
    input  logic [SIMD*TW-1:0]    in_wgt,
    output logic                  out_v,
    input  logic                  out_rdy,
    output logic [TDSTI-1:0]      out
);

    localparam int LOG_SIMD = lane_log2(SIMD);
    localparam int PW       = prod_width(TSRCI, TW);
    localparam int SW       = PW + LOG_SIMD;
    localparam int FW       = count_width(SF);
    localparam logic [FW-1:0] LAST_FOLD = FW'(SF - 1);

    typedef logic signed [TDSTI-1:0] acc_t;

`ifdef MVU_PE_SAT_EN
    localparam acc_t ACC_MAX = acc_t'({1'b0, {(TDSTI-1){1'b1}}});
    localparam acc_t ACC_MIN = acc_t'({1'b1, {(TDSTI-1){1'b0}}});
    acc_wide_t wide_sum;
`endif

    logic                    en;
    logic [SIMD*PW-1:0]      lane_prod;
    logic [SIMD*PW-1:0]      s1_prod;
    logic                    s1_v;
    logic signed [SW-1:0]    tree_sum;
    logic signed [SW-1:0]    s2_sum;
    logic                    s2_v;
    logic [FW-1:0]           fold;
    acc_t                    acc;
    acc_t                    p_ext;
    acc_t                    acc_add;
    acc_t                    acc_next;
    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    w_ext;

    assign en     = !(out_v && !out_rdy);
    assign in_rdy = en;

    // Per-lane signed products at full precision.
    always_comb begin
        lane_prod = '0;
        a_ext     = '0;
        w_ext     = '0;
        for (int i = 0; i < SIMD; i++) begin
            a_ext = PW'($signed(in_act[i*TSRCI +: TSRCI]));
            w_ext = PW'($signed(in_wgt[i*TW +: TW]));
            lane_prod[i*PW +: PW] = a_ext * w_ext;
        end
    end

    mvu_pe_adder_tree #(
        .SIMD (SIMD),
        .IW   (PW),
        .OW   (SW)
    ) u_tree (
        .terms (s1_prod),
        .sum   (tree_sum)
    );

    // Next accumulator value: fold 0 restarts the sum, later folds add to it.
    always_comb begin
        p_ext = acc_t'(s2_sum);
`ifdef MVU_PE_SAT_EN
        wide_sum = acc_wide_t'(acc) + acc_wide_t'(p_ext);
        if (wide_sum > acc_wide_t'(ACC_MAX)) begin
            acc_add = ACC_MAX;
        end else if (wide_sum < acc_wide_t'(ACC_MIN)) begin
            acc_add = ACC_MIN;
        end else begin
            acc_add = acc_t'(wide_sum);
        end
`else
        acc_add = acc + p_ext;
`endif
        acc_next = (fold == '0) ? p_ext : acc_add;
    end

    // S1/S2 stage registers and their valid bits, frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_prod <= '0;
            s2_v    <= 1'b0;
            s2_sum  <= '0;
        end else if (en) begin
            s1_v    <= in_v;
            s1_prod <= lane_prod;
            s2_v    <= s1_v;
            s2_sum  <= tree_sum;
        end
    end

    // S3: accumulate valid beats, publish on the last fold, retire on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fold  <= '0;
            acc   <= '0;
            out   <= '0;
            out_v <= 1'b0;
        end else begin
            if (out_v && out_rdy) begin
                out_v <= 1'b0;
            end
            if (en && s2_v) begin
                acc <= acc_next;
                if (fold == LAST_FOLD) begin
                    fold  <= '0;
                    out   <= acc_next;
                    out_v <= 1'b1;
                end else begin
                    fold <= fold + 1'b1;
                end
            end
        end
    end

endmodule
